// File: rtl/code_entry_buffer.sv
// Keypad code entry buffer: collects digits, supports backspace/restart,
// and locks the code on a submit that has enough digits.
//
// Ports:
//   clk, sys_reset      : clock, synchronous active-high reset
//   restart_pulse       : clear buffer and return to ENTRY
//   digit_valid/digit_in: strobe + value of an entered digit
//   backspace_pulse     : drop the most recent digit
//   submit_pulse        : request to submit the current code
//   digit_count         : digits stored, 0..MAX_DIGITS
//   empty/full/locked   : decodes of registered state
//   code_flat           : stored digits, slot 0 in the low bits
//   submit_valid        : 1-cycle pulse, code accepted
//   submit_reject       : 1-cycle pulse, too few digits
//   overflow_err        : 1-cycle pulse, digit dropped (buffer full)
module code_entry_buffer #(
  parameter int DIGIT_W    = 4,
  parameter int MAX_DIGITS = 4,
  parameter int MIN_DIGITS = 4,
  localparam int CW = $clog2(MAX_DIGITS + 1)
) (
  input  logic                          clk,
  input  logic                          sys_reset,
  input  logic                          restart_pulse,
  input  logic                          digit_valid,
  input  logic [DIGIT_W-1:0]            digit_in,
  input  logic                          backspace_pulse,
  input  logic                          submit_pulse,
  output logic [CW-1:0]                 digit_count,
  output logic                          empty,
  output logic                          full,
  output logic [MAX_DIGITS*DIGIT_W-1:0] code_flat,
  output logic                          locked,
  output logic                          submit_valid,
  output logic                          submit_reject,
  output logic                          overflow_err
);

  typedef enum logic {ENTRY, LOCKED} state_t;

  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_DIGITS);
  localparam logic [CW-1:0] MIN_C = CW'(MIN_DIGITS);

  state_t               state_q, state_n;
  logic [CW-1:0]        count_q, count_n;
  logic [DIGIT_W-1:0]   slot_q [MAX_DIGITS];
  logic [DIGIT_W-1:0]   slot_n [MAX_DIGITS];
  logic                 sv_n, sr_n, of_n;
  logic                 sv_q, sr_q, of_q;

  always_ff @(posedge clk) begin
    if (sys_reset) begin
      state_q <= ENTRY;
      count_q <= '0;
      sv_q    <= 1'b0;
      sr_q    <= 1'b0;
      of_q    <= 1'b0;
      for (int i = 0; i < MAX_DIGITS; i++)
        slot_q[i] <= '0;
    end else begin
      state_q <= state_n;
      count_q <= count_n;
      sv_q    <= sv_n;
      sr_q    <= sr_n;
      of_q    <= of_n;
      for (int i = 0; i < MAX_DIGITS; i++)
        slot_q[i] <= slot_n[i];
    end
  end

  // One action per cycle; the if-chain order is the input priority.
  always_comb begin
    state_n = state_q;
    count_n = count_q;
    sv_n    = 1'b0;
    sr_n    = 1'b0;
    of_n    = 1'b0;
    for (int i = 0; i < MAX_DIGITS; i++)
      slot_n[i] = slot_q[i];

    if (restart_pulse) begin
      state_n = ENTRY;
      count_n = '0;
      for (int i = 0; i < MAX_DIGITS; i++)
        slot_n[i] = '0;
    end else if (state_q == ENTRY) begin
      if (submit_pulse) begin
        if (count_q >= MIN_C) begin
          state_n = LOCKED;
          sv_n    = 1'b1;
        end else begin
          sr_n = 1'b1;
        end
      end else if (backspace_pulse) begin
        if (count_q != '0) begin
          count_n = count_q - ONE;
          // Clearing the vacated slot keeps unused slots at zero.
          for (int i = 0; i < MAX_DIGITS; i++)
            if (CW'(i) == count_q - ONE)
              slot_n[i] = '0;
        end
      end else if (digit_valid) begin
        if (count_q == MAX_C) begin
          of_n = 1'b1;
        end else begin
          count_n = count_q + ONE;
          for (int i = 0; i < MAX_DIGITS; i++)
            if (CW'(i) == count_q)
              slot_n[i] = digit_in;
        end
      end
    end
  end

  for (genvar g = 0; g < MAX_DIGITS; g++) begin : g_flat
    assign code_flat[g*DIGIT_W +: DIGIT_W] = slot_q[g];
  end

  assign digit_count   = count_q;
  assign empty         = (count_q == '0);
  assign full          = (count_q == MAX_C);
  assign locked        = (state_q == LOCKED);
  assign submit_valid  = sv_q;
  assign submit_reject = sr_q;
  assign overflow_err  = of_q;

endmodule

// File: tb/tb_code_entry_buffer.sv
// Directed bench for code_entry_buffer: default build plus
// a MAX_DIGITS=6 build sharing the same stimulus.
module tb_code_entry_buffer;

  logic clk = 1'b0;
  logic rst = 1'b0, rs = 1'b0, dv = 1'b0, bs = 1'b0, sb = 1'b0;
  logic [3:0] din = '0;

  logic [2:0]  count;
  logic        empty, full, locked, sv, sr, of;
  logic [15:0] flat;

  logic [2:0]  count6;
  logic        empty6, full6, locked6, sv6, sr6, of6;
  logic [23:0] flat6;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  code_entry_buffer dut (
    .clk(clk), .sys_reset(rst), .restart_pulse(rs),
    .digit_valid(dv), .digit_in(din),
    .backspace_pulse(bs), .submit_pulse(sb),
    .digit_count(count), .empty(empty), .full(full),
    .code_flat(flat), .locked(locked),
    .submit_valid(sv), .submit_reject(sr),
    .overflow_err(of)
  );

  code_entry_buffer #(
    .DIGIT_W(4), .MAX_DIGITS(6), .MIN_DIGITS(4)
  ) dut6 (
    .clk(clk), .sys_reset(rst), .restart_pulse(rs),
    .digit_valid(dv), .digit_in(din),
    .backspace_pulse(bs), .submit_pulse(sb),
    .digit_count(count6), .empty(empty6), .full(full6),
    .code_flat(flat6), .locked(locked6),
    .submit_valid(sv6), .submit_reject(sr6),
    .overflow_err(of6)
  );

  // Apply inputs for one rising edge, leave outputs sampled 1ns after it.
  task automatic cycle(input logic r, input logic re,
                       input logic d, input logic [3:0] v,
                       input logic b, input logic s);
    @(negedge clk);
    rst = r; rs = re; dv = d; din = v; bs = b; sb = s;
    @(posedge clk);
    #1;
    rst = 0; rs = 0; dv = 0; din = '0; bs = 0; sb = 0;
  endtask

  task automatic digit(input logic [3:0] v);
    cycle(0, 0, 1, v, 0, 0);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 4'h0, 0, 0);
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 4'h0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({count, empty, full, locked} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_flags got cnt=%0d e=%b f=%b l=%b exp 0 1 0 0",
               count, empty, full, locked);
    end
    tests++;
    if ({flat, sv, sr, of} !== {16'h0, 3'b000}) begin
      fails++;
      $display("FAIL reset_data got flat=%h sv/sr/of=%b%b%b exp 0000 000",
               flat, sv, sr, of);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    digit(4'd1); digit(4'd2); digit(4'd3); digit(4'd4);
    tests++;
    if ({count, full, flat} !== {3'd4, 1'b1, 16'h4321}) begin
      fails++;
      $display("FAIL fill got cnt=%0d f=%b flat=%h exp 4 1 4321",
               count, full, flat);
    end
    digit(4'd9);
    tests++;
    if ({of, count, flat} !== {1'b1, 3'd4, 16'h4321}) begin
      fails++;
      $display("FAIL ovf got of=%b cnt=%0d flat=%h exp 1 4 4321",
               of, count, flat);
    end
    idle();
    tests++;
    if (of !== 1'b0) begin
      fails++;
      $display("FAIL ovf_pulse got %b exp 0", of);
    end
  endtask

  task automatic test_backspace();
    do_reset();
    digit(4'd5); digit(4'd6);
    cycle(0, 0, 0, 4'h0, 1, 0);
    digit(4'd7);
    tests++;
    if ({count, flat} !== {3'd2, 16'h0075}) begin
      fails++;
      $display("FAIL bksp got cnt=%0d flat=%h exp 2 0075", count, flat);
    end
    repeat (3) cycle(0, 0, 0, 4'h0, 1, 0);
    tests++;
    if ({count, empty, flat, sr, of} !== {3'd0, 1'b1, 16'h0, 2'b00}) begin
      fails++;
      $display("FAIL bksp_empty got cnt=%0d e=%b flat=%h sr=%b of=%b exp 0 1 0000 0 0",
               count, empty, flat, sr, of);
    end
  endtask

  task automatic test_submit();
    do_reset();
    digit(4'd1); digit(4'd2); digit(4'd3);
    cycle(0, 0, 0, 4'h0, 0, 1);
    tests++;
    if ({sr, sv, locked, count} !== {1'b1, 1'b0, 1'b0, 3'd3}) begin
      fails++;
      $display("FAIL reject got sr=%b sv=%b l=%b cnt=%0d exp 1 0 0 3",
               sr, sv, locked, count);
    end
    idle();
    tests++;
    if (sr !== 1'b0) begin
      fails++;
      $display("FAIL reject_pulse got %b exp 0", sr);
    end
    digit(4'd8);
    cycle(0, 0, 0, 4'h0, 0, 1);
    tests++;
    if ({sv, sr, locked, flat} !== {1'b1, 1'b0, 1'b1, 16'h8321}) begin
      fails++;
      $display("FAIL accept got sv=%b sr=%b l=%b flat=%h exp 1 0 1 8321",
               sv, sr, locked, flat);
    end
    idle();
    tests++;
    if ({sv, locked} !== 2'b01) begin
      fails++;
      $display("FAIL accept_pulse got sv=%b l=%b exp 0 1", sv, locked);
    end
  endtask

  // Continues from the LOCKED state left by test_submit.
  task automatic test_locked();
    digit(4'd3);
    tests++;
    if ({count, flat, locked, of} !== {3'd4, 16'h8321, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL lock_digit got cnt=%0d flat=%h l=%b of=%b exp 4 8321 1 0",
               count, flat, locked, of);
    end
    cycle(0, 0, 0, 4'h0, 1, 0);
    cycle(0, 0, 0, 4'h0, 0, 1);
    tests++;
    if ({count, flat, sv, sr, of} !== {3'd4, 16'h8321, 3'b000}) begin
      fails++;
      $display("FAIL lock_hold got cnt=%0d flat=%h sv/sr/of=%b%b%b exp 4 8321 000",
               count, flat, sv, sr, of);
    end
    cycle(0, 1, 0, 4'h0, 0, 0);
    tests++;
    if ({locked, count, flat, empty} !== {1'b0, 3'd0, 16'h0, 1'b1}) begin
      fails++;
      $display("FAIL restart got l=%b cnt=%0d flat=%h e=%b exp 0 0 0000 1",
               locked, count, flat, empty);
    end
  endtask

  task automatic test_priority();
    do_reset();
    digit(4'd1); digit(4'd2); digit(4'd3); digit(4'd4);
    cycle(0, 0, 1, 4'd9, 0, 1);
    tests++;
    if ({sv, of, locked, flat} !== {1'b1, 1'b0, 1'b1, 16'h4321}) begin
      fails++;
      $display("FAIL prio_sub got sv=%b of=%b l=%b flat=%h exp 1 0 1 4321",
               sv, of, locked, flat);
    end
    cycle(1, 1, 1, 4'd5, 1, 1);
    tests++;
    if ({locked, count, flat, empty, sv, sr, of} !==
        {1'b0, 3'd0, 16'h0, 1'b1, 3'b000}) begin
      fails++;
      $display("FAIL prio_rst got l=%b cnt=%0d flat=%h e=%b pulses=%b%b%b exp 0 0 0000 1 000",
               locked, count, flat, empty, sv, sr, of);
    end
    digit(4'd6); digit(4'd7);
    cycle(0, 1, 1, 4'd9, 1, 1);
    tests++;
    if ({count, flat, sv, sr} !== {3'd0, 16'h0, 2'b00}) begin
      fails++;
      $display("FAIL prio_rs got cnt=%0d flat=%h sv=%b sr=%b exp 0 0000 0 0",
               count, flat, sv, sr);
    end
  endtask

  task automatic test_param6();
    do_reset();
    digit(4'd1); digit(4'd2); digit(4'd3); digit(4'd4);
    tests++;
    if ({count6, full6} !== {3'd4, 1'b0}) begin
      fails++;
      $display("FAIL p6_fill4 got cnt=%0d f=%b exp 4 0", count6, full6);
    end
    cycle(0, 0, 0, 4'h0, 0, 1);
    tests++;
    if ({sv6, sr6, locked6, flat6} !== {1'b1, 1'b0, 1'b1, 24'h004321}) begin
      fails++;
      $display("FAIL p6_accept got sv=%b sr=%b l=%b flat=%h exp 1 0 1 004321",
               sv6, sr6, locked6, flat6);
    end
    do_reset();
    for (int i = 1; i <= 6; i++) digit(4'(i));
    tests++;
    if ({count6, full6, flat6} !== {3'd6, 1'b1, 24'h654321}) begin
      fails++;
      $display("FAIL p6_full got cnt=%0d f=%b flat=%h exp 6 1 654321",
               count6, full6, flat6);
    end
    digit(4'd9);
    tests++;
    if ({of6, count6, flat6} !== {1'b1, 3'd6, 24'h654321}) begin
      fails++;
      $display("FAIL p6_ovf got of=%b cnt=%0d flat=%h exp 1 6 654321",
               of6, count6, flat6);
    end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_backspace();
    test_submit();
    test_locked();
    test_priority();
    test_param6();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/code_entry_buffer.md
CODE_ENTRY_BUFFER -- requirements
Module: code_entry_buffer

Interface
REQ-001 SHALL provide parameter DIGIT_W, default 4, meaning bits per entered digit.
REQ-002 SHALL provide parameter MAX_DIGITS, default 4, meaning buffer depth and maximum code length (range 1..16).
REQ-003 SHALL provide parameter MIN_DIGITS, default 4, meaning the fewest digits a submit accepts (range 1..MAX_DIGITS).
REQ-004 SHALL define local CW = clog2(MAX_DIGITS+1) as the count width.
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 sys_reset  input  1  global reset; synchronous, active-high.
REQ-007 restart_pulse  input  1  abandon current attempt; clear buffer.
REQ-008 digit_valid  input  1  one-cycle strobe; digit_in is valid this cycle.
REQ-009 digit_in  input  DIGIT_W  entered digit value.
REQ-010 backspace_pulse  input  1  remove most recent digit.
REQ-011 submit_pulse  input  1  request to submit the current code.
REQ-012 digit_count  output  CW  digits currently stored, 0..MAX_DIGITS.
REQ-013 empty  output  1  high when digit_count == 0.
REQ-014 full  output  1  high when digit_count == MAX_DIGITS.
REQ-015 code_flat  output  MAX_DIGITS*DIGIT_W  stored digits; slot 0 (first entered) in bits [DIGIT_W-1:0].
REQ-016 locked  output  1  high while in LOCKED state.
REQ-017 submit_valid  output  1  one-cycle pulse: code accepted, code_flat/digit_count stable.
REQ-018 submit_reject  output  1  one-cycle pulse: submit refused (too few digits).
REQ-019 overflow_err  output  1  one-cycle pulse: digit dropped because buffer full.

Function
REQ-020 SHALL implement a two-state FSM: ENTRY and LOCKED.
REQ-021 Per-cycle input priority SHALL be sys_reset > restart_pulse > submit_pulse > backspace_pulse > digit_valid; at most one action per cycle, lower-priority inputs that cycle are discarded with no error pulse.
REQ-022 ENTRY, digit_valid, not full: digit_in written to slot digit_count, digit_count +1, next cycle.
REQ-023 ENTRY, digit_valid, full: buffer and count unchanged; overflow_err pulses next cycle.
REQ-024 ENTRY, backspace_pulse, count > 0: slot count-1 cleared to 0, count -1; when empty: no-op, no error.
REQ-025 ENTRY, submit_pulse, count >= MIN_DIGITS: go to LOCKED; submit_valid pulses next cycle (latency 1).
REQ-026 ENTRY, submit_pulse, count < MIN_DIGITS: stay ENTRY, buffer unchanged; submit_reject pulses next cycle.
REQ-027 LOCKED: digit_valid, backspace_pulse, submit_pulse ignored, no error pulses; code_flat and digit_count held.
REQ-028 restart_pulse in either state: all slots and count cleared to 0, state ENTRY, next cycle; pending pulse outputs low.
REQ-029 Unused slots (index >= digit_count) SHALL always read 0.
REQ-030 empty, full, locked SHALL be combinational decodes of registered state; all pulse outputs registered, high exactly one cycle.
REQ-031 Count SHALL never exceed MAX_DIGITS nor wrap below 0.

Reset
REQ-032 On sys_reset high at a clock edge: state ENTRY, digit_count 0, code_flat 0, submit_valid/submit_reject/overflow_err 0, empty 1, full 0, locked 0.
REQ-033 sys_reset mid-entry or in LOCKED SHALL abort unconditionally, overriding every other input that cycle.

Verification (defaults DIGIT_W=4, MAX=4, MIN=4)
REQ-034 Enter 1,2,3,4 -> count 4, full 1, code_flat 16'h4321; fifth digit 9 -> overflow_err one pulse, code_flat 16'h4321.
REQ-035 Enter 5,6, backspace, 7 -> count 2, code_flat 16'h0075; backspace x3 -> count 0, empty 1, no error.
REQ-036 Enter 1,2,3, submit -> submit_reject one pulse, state ENTRY, count 3; enter 8, submit -> submit_valid one pulse, locked 1, code_flat 16'h8321.
REQ-037 In LOCKED: digit 3, backspace, submit -> no change, no pulses; restart_pulse -> locked 0, count 0, code_flat 0.
REQ-038 Same cycle submit_pulse + digit_valid with count 4 -> submit wins, digit dropped, no overflow_err; same cycle restart + sys_reset -> reset values.
REQ-039 Rerun REQ-034/036 with MAX_DIGITS=6, MIN_DIGITS=4, DIGIT_W=4: 4-digit submit accepted, 7th digit flags overflow_err.
